// File: rtl/control_unit.sv
// Multi-cycle control FSM for a small 16-bit ALU datapath: fetch, PC increment,
// decode, execute and write-back of ADD/SUB/CMP in register and immediate forms.
module control_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        memory_ready,
   input  logic [15:0] instruction,
   output logic [1:0]  alu_a_select,
   output logic        alu_b_select,
   output logic [1:0]  alu_operation,
   output logic        program_counter_write_enable,
   output logic        instruction_write_enable,
   output logic        status_write_enable,
   output logic        register_write_enable,
   output logic        illegal_instruction,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      FETCH     = 3'b000,
      INCREMENT = 3'b001,
      DECODE    = 3'b010,
      EXECUTE   = 3'b011,
      WRITEBACK = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_CMP = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic    legal;
      logic    immediate;
      alu_op_t operation;
      logic    writes_back;
   } decode_t;

   state_t     current;
   decode_t    decoded;
   logic [3:0] opcode;
   logic [3:0] extension;

   assign opcode    = instruction[15:12];
   assign extension = instruction[7:4];

   // Register and immediate fields are consumed by the datapath, not here.
   logic unused_instruction_bits;
   assign unused_instruction_bits = ^{instruction[11:8], instruction[3:0]};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      decoded = '{legal: 1'b0, immediate: 1'b0, operation: ALU_ADD, writes_back: 1'b0};
      unique case (opcode)
         4'b0000: begin
            unique case (extension)
               4'b0101: decoded = '{legal: 1'b1, immediate: 1'b0, operation: ALU_ADD, writes_back: 1'b1};
               4'b1001: decoded = '{legal: 1'b1, immediate: 1'b0, operation: ALU_SUB, writes_back: 1'b1};
               4'b1011: decoded = '{legal: 1'b1, immediate: 1'b0, operation: ALU_CMP, writes_back: 1'b0};
               default: ;
            endcase
         end
         4'b0101: decoded = '{legal: 1'b1, immediate: 1'b1, operation: ALU_ADD, writes_back: 1'b1};
         4'b1001: decoded = '{legal: 1'b1, immediate: 1'b1, operation: ALU_SUB, writes_back: 1'b1};
         4'b1011: decoded = '{legal: 1'b1, immediate: 1'b1, operation: ALU_CMP, writes_back: 1'b0};
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         current <= FETCH;
      end else begin
         case (current)
            FETCH:     if (memory_ready) current <= INCREMENT;
            INCREMENT: current <= DECODE;
            DECODE:    current <= decoded.legal ? EXECUTE : FETCH;
            EXECUTE:   current <= (decoded.legal && decoded.writes_back) ? WRITEBACK : FETCH;
            WRITEBACK: current <= FETCH;
            default:   current <= FETCH;
         endcase
      end
   end

   assign state = current;

   // Enables are gated by reset in the same cycle so a reset mid-instruction
   // never lets a status or register write slip through.
   always_comb begin
      alu_a_select                 = 2'b00;
      alu_b_select                 = 1'b0;
      alu_operation                = ALU_ADD;
      program_counter_write_enable = 1'b0;
      instruction_write_enable     = 1'b0;
      status_write_enable          = 1'b0;
      register_write_enable        = 1'b0;
      illegal_instruction          = 1'b0;
      case (current)
         FETCH: instruction_write_enable = memory_ready & ~reset;
         INCREMENT: begin
            alu_b_select                 = 1'b1;
            program_counter_write_enable = ~reset;
         end
         DECODE: illegal_instruction = ~decoded.legal & ~reset;
         EXECUTE: begin
            if (decoded.legal) begin
               alu_a_select        = decoded.immediate ? 2'b10 : 2'b01;
               alu_operation       = decoded.operation;
               status_write_enable = ~reset;
            end
         end
         WRITEBACK: register_write_enable = ~reset;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: cycle-by-cycle vector table followed by
// bounded latency measurements per instruction class.
module tb_control_unit;

   logic        clock;
   logic        reset;
   logic        memory_ready;
   logic [15:0] instruction;
   logic [1:0]  alu_a_select;
   logic        alu_b_select;
   logic [1:0]  alu_operation;
   logic        program_counter_write_enable;
   logic        instruction_write_enable;
   logic        status_write_enable;
   logic        register_write_enable;
   logic        illegal_instruction;
   logic [2:0]  state;

   int checks   = 0;
   int failures = 0;

   control_unit dut (
      .clock                        (clock),
      .reset                        (reset),
      .memory_ready                 (memory_ready),
      .instruction                  (instruction),
      .alu_a_select                 (alu_a_select),
      .alu_b_select                 (alu_b_select),
      .alu_operation                (alu_operation),
      .program_counter_write_enable (program_counter_write_enable),
      .instruction_write_enable     (instruction_write_enable),
      .status_write_enable          (status_write_enable),
      .register_write_enable        (register_write_enable),
      .illegal_instruction          (illegal_instruction),
      .state                        (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected word: {state, a_sel, b_sel, alu_op, pc_we, ir_we, st_we, rf_we, illegal}
   typedef struct {
      logic        rst;
      logic        ready;
      logic [15:0] ins;
      logic [12:0] expected;
   } vec_t;

   vec_t vectors[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   task automatic add(input logic rst, input logic ready, input logic [15:0] ins,
                      input logic [2:0] st, input logic [1:0] a, input logic b,
                      input logic [1:0] op, input logic pc, input logic iw,
                      input logic sw, input logic rw, input logic il);
      vec_t v;
      v.rst      = rst;
      v.ready    = ready;
      v.ins      = ins;
      v.expected = {st, a, b, op, pc, iw, sw, rw, il};
      vectors.push_back(v);
   endtask

   function automatic logic [12:0] observed();
      return {state, alu_a_select, alu_b_select, alu_operation, program_counter_write_enable,
              instruction_write_enable, status_write_enable, register_write_enable,
              illegal_instruction};
   endfunction

   // Runs one instruction from FETCH with memory_ready held high and returns
   // the cycle count back to FETCH plus how often write/illegal strobes fired.
   task automatic run_instruction(input string name, input logic [15:0] ins,
                                  input int exp_cycles, input int exp_writes, input int exp_illegal);
      int cycles;
      int writes;
      int illegals;
      bit done;
      cycles = 0; writes = 0; illegals = 0; done = 0;
      check({name, "_start_state"}, 32'(state), 32'd0);
      instruction  = ins;
      memory_ready = 1'b1;
      while (!done) begin
         #1;
         writes   += int'(register_write_enable);
         illegals += int'(illegal_instruction);
         @(posedge clock);
         #1;
         cycles++;
         if (state == 3'b000 || cycles >= 20) done = 1;
      end
      memory_ready = 1'b0;
      check({name, "_latency"}, 32'(cycles), 32'(exp_cycles));
      check({name, "_rf_writes"}, 32'(writes), 32'(exp_writes));
      check({name, "_illegal"}, 32'(illegals), 32'(exp_illegal));
      @(negedge clock);
   endtask

   initial begin
      // rst rdy ins      st      a     b     op     pc iw sw rw il
      // ADD R (0x0152): full five-state walk
      add(0, 0, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b011, 2'b01, 1'b0, 2'b00, 0, 0, 1, 0, 0);
      add(0, 1, 16'h0152, 3'b100, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 0);
      // ADDI (0x5307)
      add(0, 1, 16'h5307, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h5307, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h5307, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h5307, 3'b011, 2'b10, 1'b0, 2'b00, 0, 0, 1, 0, 0);
      add(0, 1, 16'h5307, 3'b100, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 0);
      // CMP R (0x04B1): no write-back
      add(0, 1, 16'h04B1, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h04B1, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h04B1, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h04B1, 3'b011, 2'b01, 1'b0, 2'b10, 0, 0, 1, 0, 0);
      // Illegal opcode (0xF000)
      add(0, 1, 16'hF000, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'hF000, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'hF000, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 1);
      // Memory stall for three cycles, then SUBI (0x9105)
      add(0, 0, 16'h9105, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 0, 16'h9105, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 0, 16'h9105, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h9105, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h9105, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h9105, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h9105, 3'b011, 2'b10, 1'b0, 2'b01, 0, 0, 1, 0, 0);
      add(0, 1, 16'h9105, 3'b100, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 0);
      // SUB R (0x0191) with reset in EXECUTE: status write blocked, no WRITEBACK
      add(0, 1, 16'h0191, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h0191, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h0191, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(1, 1, 16'h0191, 3'b011, 2'b01, 1'b0, 2'b01, 0, 0, 0, 0, 0);
      add(0, 0, 16'h0191, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      // ADD with reset in WRITEBACK: register write suppressed
      add(0, 1, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0152, 3'b011, 2'b01, 1'b0, 2'b00, 0, 0, 1, 0, 0);
      add(1, 1, 16'h0152, 3'b100, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 0, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      // Reset in FETCH with memory ready: instruction load blocked, stays in FETCH
      add(1, 1, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 0, 16'h0152, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      // Opcode 0000 with undefined extension 0011 is illegal
      add(0, 1, 16'h0A31, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'h0A31, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'h0A31, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 1);
      add(0, 0, 16'h0A31, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      // CMPI (0xB123)
      add(0, 1, 16'hB123, 3'b000, 2'b00, 1'b0, 2'b00, 0, 1, 0, 0, 0);
      add(0, 1, 16'hB123, 3'b001, 2'b00, 1'b1, 2'b00, 1, 0, 0, 0, 0);
      add(0, 1, 16'hB123, 3'b010, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);
      add(0, 1, 16'hB123, 3'b011, 2'b10, 1'b0, 2'b10, 0, 0, 1, 0, 0);
      add(0, 0, 16'hB123, 3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0);

      reset        = 1'b1;
      memory_ready = 1'b0;
      instruction  = 16'h0000;
      repeat (2) @(negedge clock);

      for (int i = 0; i < vectors.size(); i++) begin
         reset        = vectors[i].rst;
         memory_ready = vectors[i].ready;
         instruction  = vectors[i].ins;
         #1;
         check($sformatf("row%0d", i), 32'(observed()), 32'(vectors[i].expected));
         @(negedge clock);
      end

      reset        = 1'b0;
      memory_ready = 1'b0;
      run_instruction("add",   16'h0152, 5, 1, 0);
      run_instruction("addi",  16'h5307, 5, 1, 0);
      run_instruction("subi",  16'h9105, 5, 1, 0);
      run_instruction("cmp",   16'h04B1, 4, 0, 0);
      run_instruction("cmpi",  16'hB123, 4, 0, 0);
      run_instruction("illeg", 16'hF000, 3, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
